// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C_Controller between several configuration
// requesters, sequencing START/END, retrying NACKs and bounding each attempt with a timeout.
module i2c_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [NREQ-1:0]      iREQ,
    input  logic [24*NREQ-1:0]   iDATA,
    output logic [NREQ-1:0]      oGNT,
    output logic [NREQ-1:0]      oDONE,
    output logic [NREQ-1:0]      oERR,
    output logic                 oBUSY,
    output logic [23:0]          oI2C_DATA,
    output logic                 oI2C_START,
    input  logic                 iI2C_END,
    input  logic                 iI2C_ACK
);

    localparam int unsigned DW = 24;
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_END, DONE} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt, winner;
    logic              found;
    logic [RW-1:0]     retry, retry_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [NREQ-1:0]   gnt_nxt, done_nxt, err_nxt;
    logic [DW-1:0]     data_nxt;
    logic              start_nxt, busy_nxt;
    logic [DW-1:0]     words [NREQ];

    // Unpack the per-requester words so the winner can select one directly
    always_comb begin
        for (int k = 0; k < int'(NREQ); k++) begin
            words[k] = iDATA[k*DW +: DW];
        end
    end

    // Round-robin search starting just after the last winner, wrapping at NREQ
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            int idx;
            idx = (int'(ptr) + i) % int'(NREQ);
            if (!found && iREQ[PW'(idx)]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        retry_nxt = retry;
        timer_nxt = timer;
        gnt_nxt   = oGNT;
        done_nxt  = oDONE;
        err_nxt   = oERR;
        data_nxt  = oI2C_DATA;
        start_nxt = oI2C_START;

        case (state)
            IDLE: begin
                if (found && iI2C_END) begin
                    gnt_nxt   = NREQ'(1) << winner;
                    ptr_nxt   = winner;
                    data_nxt  = words[winner];
                    start_nxt = 1'b1;
                    retry_nxt = '0;
                    timer_nxt = '0;
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW, WAIT_END: begin
                // Timeout overrides any handshake progress and is never retried
                if (timer == TW'(TIMEOUT - 1)) begin
                    start_nxt = 1'b0;
                    done_nxt  = oGNT;
                    err_nxt   = oGNT;
                    state_nxt = DONE;
                end else begin
                    timer_nxt = timer + TW'(1);
                    if (state == WAIT_LOW) begin
                        if (!iI2C_END) begin
                            start_nxt = 1'b0;
                            state_nxt = WAIT_END;
                        end
                    end else if (iI2C_END) begin
                        if (!iI2C_ACK) begin
                            done_nxt  = oGNT;
                            err_nxt   = '0;
                            state_nxt = DONE;
                        end else if (retry < RW'(MAX_RETRY)) begin
                            retry_nxt = retry + RW'(1);
                            timer_nxt = '0;
                            start_nxt = 1'b1;
                            state_nxt = WAIT_LOW;
                        end else begin
                            done_nxt  = oGNT;
                            err_nxt   = oGNT;
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done_nxt  = '0;
                err_nxt   = '0;
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            ptr        <= PW'(NREQ - 1);
            retry      <= '0;
            timer      <= '0;
            oGNT       <= '0;
            oDONE      <= '0;
            oERR       <= '0;
            oBUSY      <= 1'b0;
            oI2C_DATA  <= '0;
            oI2C_START <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            retry      <= retry_nxt;
            timer      <= timer_nxt;
            oGNT       <= gnt_nxt;
            oDONE      <= done_nxt;
            oERR       <= err_nxt;
            oBUSY      <= busy_nxt;
            oI2C_DATA  <= data_nxt;
            oI2C_START <= start_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a behavioural I2C_Controller model
// (END handshake, scripted NACKs, optional hang for the timeout case).
module tb_i2c_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [24*NREQ-1:0] data = '0;
    logic [NREQ-1:0]   gnt, done, err;
    logic              busy, start;
    logic [23:0]       i2c_data;
    logic              i2c_end = 1'b1;
    logic              i2c_ack = 1'b0;

    int vectors = 0;
    int errs = 0;

    // controller model state
    int          start_pulses = 0;
    int          data_changes = 0;
    logic [23:0] last_data = '0;
    bit          mdl_busy = 1'b0;
    int          mdl_cnt = 0;
    int          base = 0;
    int          nack_limit = 0;
    bit          hang = 1'b0;

    i2c_arbiter #(.NREQ(NREQ), .MAX_RETRY(3), .TIMEOUT(100)) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iREQ      (req),
        .iDATA     (data),
        .oGNT      (gnt),
        .oDONE     (done),
        .oERR      (err),
        .oBUSY     (busy),
        .oI2C_DATA (i2c_data),
        .oI2C_START(start),
        .iI2C_END  (i2c_end),
        .iI2C_ACK  (i2c_ack)
    );

    always #5 clk = ~clk;

    // Controller: drops END on START, returns it 5 cycles later with a scripted ACK
    always @(negedge clk) begin
        if (mdl_busy) begin
            mdl_cnt++;
            if (mdl_cnt == 5) begin
                i2c_ack  = ((start_pulses - base) <= nack_limit);
                i2c_end  = 1'b1;
                mdl_busy = 1'b0;
            end
        end else if (start && i2c_end) begin
            i2c_end = 1'b0;
            start_pulses++;
            if (i2c_data != last_data) data_changes++;
            last_data = i2c_data;
            if (!hang) begin
                mdl_busy = 1'b1;
                mdl_cnt  = 0;
            end
        end else if (!i2c_end && !hang) begin
            i2c_end = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            sample();
            n++;
        end while (done == '0 && n < budget);
        if (done == '0) check("done_wait_expired", 32'(done != '0), 32'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        sample();
        rst_n = 1'b1;
        sample();
    endtask

    // Grant must be one-hot whenever it is asserted
    initial forever begin
        sample();
        if (gnt != '0) check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] exp_gnt [6];
        logic [23:0]     exp_dat [6];
        int              chg, n;
        exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        exp_dat = '{24'h724110, 24'h111111, 24'h333333, 24'h724110, 24'h111111, 24'h333333};

        // reset values
        repeat (2) sample();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(i2c_data), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        rst_n = 1'b1;
        sample();

        // single write
        data[23:0] = 24'h724110;
        req = 4'b0001;
        sample();
        check("t1_start", 32'(start), 32'd1);
        check("t1_data", 32'(i2c_data), 32'h724110);
        check("t1_gnt", 32'(gnt), 32'b0001);
        check("t1_busy", 32'(busy), 32'd1);
        sample();
        check("t1_start_low", 32'(start), 32'd0);
        wait_done(50);
        check("t1_done", 32'(done), 32'b0001);
        check("t1_err", 32'(err), 32'd0);
        req = '0;
        sample();
        check("t1_done_1cyc", 32'(done), 32'd0);
        check("t1_gnt_clr", 32'(gnt), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_pulses", 32'(start_pulses), 32'd1);

        // contention, pointer fresh from reset
        pulse_reset();
        data[47:24] = 24'h111111;
        data[95:72] = 24'h333333;
        req = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_done(50);
            check("t2_gnt", 32'(gnt), 32'(exp_gnt[k]));
            check("t2_done", 32'(done), 32'(exp_gnt[k]));
            check("t2_err", 32'(err), 32'd0);
            check("t2_data", 32'(i2c_data), 32'(exp_dat[k]));
        end
        req = '0;
        repeat (2) sample();

        // two NACKs then success
        base = start_pulses;
        chg = data_changes;
        nack_limit = 2;
        data[47:24] = 24'hA55A3C;
        req = 4'b0010;
        wait_done(100);
        check("t3_done", 32'(done), 32'b0010);
        check("t3_err", 32'(err), 32'd0);
        check("t3_pulses", 32'(start_pulses - base), 32'd3);
        check("t3_same_data", 32'(data_changes - chg), 32'd1);
        check("t3_data", 32'(i2c_data), 32'hA55A3C);
        req = '0;
        nack_limit = 0;
        sample();

        // retries exhausted
        base = start_pulses;
        chg = data_changes;
        nack_limit = 1000;
        data[95:72] = 24'h123456;
        req = 4'b1000;
        wait_done(200);
        check("t4_done", 32'(done), 32'b1000);
        check("t4_err", 32'(err), 32'b1000);
        check("t4_pulses", 32'(start_pulses - base), 32'd4);
        check("t4_same_data", 32'(data_changes - chg), 32'd1);
        req = '0;
        nack_limit = 0;
        sample();

        // timeout with END stuck low
        base = start_pulses;
        hang = 1'b1;
        data[71:48] = 24'h0F0F0F;
        req = 4'b0100;
        sample();
        check("t5_start", 32'(start), 32'd1);
        check("t5_gnt", 32'(gnt), 32'b0100);
        n = 0;
        do begin
            sample();
            n++;
        end while (done == '0 && n < 200);
        check("t5_cycles", 32'(n), 32'd100);
        check("t5_done", 32'(done), 32'b0100);
        check("t5_err", 32'(err), 32'b0100);
        check("t5_start_low", 32'(start), 32'd0);
        req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            sample();
            check("t5_no_grant", 32'(busy), 32'd0);
        end
        check("t5_no_retry", 32'(start_pulses - base), 32'd1);
        hang = 1'b0;
        n = 0;
        do begin
            sample();
            n++;
        end while (!start && n < 10);
        check("t5_regrant_lat", 32'(n), 32'd2);
        check("t5_regrant_gnt", 32'(gnt), 32'b0001);
        check("t5_regrant_data", 32'(i2c_data), 32'h724110);
        wait_done(50);
        check("t5_next_done", 32'(done), 32'b0001);
        check("t5_next_err", 32'(err), 32'd0);
        req = '0;
        sample();

        // reset while waiting for END
        base = start_pulses;
        data[71:48] = 24'hC0FFEE;
        req = 4'b0100;
        sample();
        check("t6_start", 32'(start), 32'd1);
        sample();
        check("t6_wait_end", 32'(start), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_start", 32'(start), 32'd0);
        check("t6_rst_data", 32'(i2c_data), 32'd0);
        sample();
        rst_n = 1'b1;
        n = 0;
        while (!i2c_end && n < 20) begin
            check("t6_hold_gnt", 32'(gnt), 32'd0);
            sample();
            n++;
        end
        check("t6_end_back", 32'(i2c_end), 32'd1);
        sample();
        check("t6_gnt", 32'(gnt), 32'b0100);
        check("t6_start2", 32'(start), 32'd1);
        check("t6_data", 32'(i2c_data), 32'hC0FFEE);
        wait_done(50);
        check("t6_done", 32'(done), 32'b0100);
        check("t6_err", 32'(err), 32'd0);
        req = '0;
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter and transfer sequencer that shares one I2C_Controller instance (400 kHz, 24-bit {slave, sub-address, data} writes) between several configuration requesters: HDMI transmitter init, audio codec init, and runtime register writes. It grants one requester at a time and runs the controller's START/END handshake. It retries NACKed writes, bounds each attempt with a timeout, and reports per-requester completion and error status. It sits between the requesters and the single I2C_Controller instance that drives the board I2C pins.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- MAX_RETRY, 3: re-attempts after a NACK; total attempts = MAX_RETRY+1.
- TIMEOUT, 1_000_000: iCLK cycles allowed per attempt (20 ms at 50 MHz).

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  reset: asynchronous, active-low.
- iREQ  in  NREQ  per-requester request level; held until its oDONE.
- iDATA  in  24*NREQ  requester k's word in bits [24k+23:24k] = {slave addr, sub addr, data}.
- oGNT  out  NREQ  one-hot grant; high for the whole transaction, including the DONE cycle.
- oDONE  out  NREQ  one-cycle completion pulse to the granted requester.
- oERR  out  NREQ  valid with oDONE; 1 means retries exhausted or timeout.
- oBUSY  out  1  high in every state except IDLE.
- oI2C_DATA  out  24  word driven to the controller.
- oI2C_START  out  1  controller start.
- iI2C_END  in  1  controller end/idle flag.
- iI2C_ACK  in  1  controller ACK status; 1 = NACK/failure, 0 = success.

## Operation
States: IDLE, WAIT_LOW, WAIT_END, DONE.

- **IDLE**
  - Transition fires when any iREQ bit is set and iI2C_END=1.
  - Winner is the first set bit searching upward from ptr+1, modulo NREQ.
  - On that edge: oGNT = onehot(winner); ptr <= winner; latch iDATA slice into oI2C_DATA; oI2C_START <= 1; retry count <= 0; timer <= 0; go to WAIT_LOW.
- **WAIT_LOW**
  - On iI2C_END=0: oI2C_START <= 0, go to WAIT_END.
- **WAIT_END**
  - On iI2C_END=1, sample iI2C_ACK:
  - ACK=0: oDONE[winner] <= 1, oERR <= 0, go to DONE.
  - ACK=1 and retry count < MAX_RETRY: retry count++, timer <= 0, oI2C_START <= 1, go to WAIT_LOW. The same latched word is re-issued.
  - ACK=1 and retries exhausted: oDONE and oERR for winner <= 1, go to DONE.
- **Timeout**
  - Timer increments in WAIT_LOW and WAIT_END.
  - When timer reaches TIMEOUT-1: oI2C_START <= 0, oDONE and oERR <= 1, go to DONE.
  - A timeout is never retried.
- **DONE**
  - Lasts exactly one cycle.
  - On exit: oDONE, oERR and oGNT <= 0; go to IDLE.
- Requester rules:
  - A requester samples oDONE and drops iREQ on that edge.
  - An iREQ still high in IDLE is treated as a new request.
  - Dropping iREQ mid-transaction does not abort it.
  - iDATA changes after the grant edge do not affect the transfer.
- Round-robin pointer:
  - ptr resets to NREQ-1, so requester 0 has first priority after reset.
  - The search index wraps from NREQ-1 to 0.
- Simultaneous requests: the lowest index at or after ptr+1 wins. Every continuously requesting requester is served within NREQ transactions.
- Timer width is $clog2(TIMEOUT+1).

## Timing
- Reset values: oGNT=0, oDONE=0, oERR=0, oBUSY=0, oI2C_DATA=0, oI2C_START=0, ptr=NREQ-1, state IDLE.
- Reset assertion mid-transfer clears all outputs immediately. The controller is left to finish on its own. After release, IDLE waits for iI2C_END=1 before issuing a start.
- Latency from iREQ to oI2C_START is 1 cycle, provided iI2C_END=1.
- oI2C_START deasserts on the edge after the first cycle with iI2C_END=0.
- oDONE rises on the edge after iI2C_END returns to 1, and lasts 1 cycle.
- Earliest re-grant is the cycle after DONE, i.e. 2 cycles after oDONE rises.
- A retry re-asserts oI2C_START 1 cycle after the NACK is sampled.
- Only registered outputs are used; there are no combinational paths from inputs to outputs.

## Test plan
- Single write: iREQ=4'b0001, data 24'h72_41_10, controller model ACK=0 → oI2C_START 1 cycle later with oI2C_DATA=24'h724110; oDONE[0] 1 cycle, oERR=0.
- Contention: iREQ=4'b1011 held continuously, all ACK=0 → grant order 0,1,3,0,1,3; oGNT always one-hot.
- NACK then success: first two attempts ACK=1, third ACK=0 → 3 START pulses with identical data; oDONE with oERR=0.
- Retry exhaustion: ACK=1 always, MAX_RETRY=3 → exactly 4 START pulses; oDONE and oERR both high for requester k.
- Timeout: iI2C_END held 0 after start, TIMEOUT=100 → oDONE+oERR at cycle 100 of the attempt; no retry; next grant only after iI2C_END returns to 1.
- Reset mid-WAIT_END: assert iRST_N=0 → all outputs 0 at once; after release with iREQ=4'b0100, requester 2 is granted only once iI2C_END=1.
